phrase_sequencer: RTL and testbench

Queues spoken-word codes (digits, operators, "equals", etc.) and plays them back-to-back through the audio playback controller. The block sits directly upstream of the audio controller. For each queued word it:
- fetches that word's byte-address range from a registered address ROM,
- drives `start_address`/`end_address`,
- issues a start request and waits for playback to finish,
- inserts a fixed silence gap before the next word.

---
 rtl/phrase_sequencer.sv | 177 +++++++++++++++++
 tb/tb_phrase_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phrase_sequencer.sv
// ============================================================================
// Module   : phrase_sequencer
// Purpose  : Queues spoken-word codes and plays them back-to-back through the
//            audio playback controller, with a silence gap between words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phrase_sequencer #(
  parameter int                DEPTH        = 8,
  parameter int                WORD_W       = 5,
  parameter int                GAP_CYCLES   = 2500000,
  parameter int                ACK_TIMEOUT  = 16,
  parameter logic [WORD_W-1:0] SILENCE_CODE = 5'h1F
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WORD_W-1:0]          word_code,
  input  logic                       clear,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic [WORD_W-1:0]          tbl_index,
  input  logic [23:0]                tbl_start,
  input  logic [23:0]                tbl_end,
  output logic [23:0]                start_address,
  output logic [23:0]                end_address,
  output logic                       play_start,
  input  logic                       play_finish,
  output logic                       ack_error
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_TO_W  = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOOKUP = 3'd2,
    S_LATCH  = 3'd3,
    S_REQ    = 3'd4,
    S_PLAY   = 3'd5,
    S_GAP    = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [WORD_W-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [WORD_W-1:0]   r_cur;
  logic [31:0]         r_gap_cnt;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic [23:0]         r_start_addr;
  logic [23:0]         r_end_addr;
  logic                r_play_start;
  logic                r_ack_error;

  logic                w_full;
  logic                w_push_ok;
  logic                w_pop;
  logic                w_fetch_go;
  logic                w_gap_done;
  logic                w_to_done;
  logic                w_ack_set;

  assign w_full     = (r_count == c_CNT_W'(DEPTH));
  assign w_push_ok  = push && !w_full && !clear;
  assign w_pop      = (r_state == S_FETCH);
  // A clear in the same cycle must not launch a fetch of a flushed word.
  assign w_fetch_go = (r_state == S_IDLE) && (r_count != '0) && !clear;
  assign w_gap_done = ({1'b0, r_gap_cnt} + 33'd1) >= 33'(GAP_CYCLES);
  assign w_to_done  = (r_to_cnt == c_TO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= word_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ack_set    = 1'b0;
    case (r_state)
      S_IDLE:   if (w_fetch_go) w_state_next = S_FETCH;
      S_FETCH:  w_state_next = (r_cur == SILENCE_CODE) ? S_GAP : S_LOOKUP;
      S_LOOKUP: w_state_next = S_LATCH;
      S_LATCH:  w_state_next = S_REQ;
      S_REQ: begin
        if (!play_finish) begin
          w_state_next = S_PLAY;
        end else if (w_to_done) begin
          w_state_next = S_GAP;
          w_ack_set    = 1'b1;
        end
      end
      S_PLAY:   if (play_finish) w_state_next = S_GAP;
      S_GAP:    if (w_gap_done) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_gap_cnt    <= '0;
      r_to_cnt     <= '0;
      r_cur        <= '0;
      r_start_addr <= '0;
      r_end_addr   <= '0;
      r_play_start <= 1'b0;
      r_ack_error  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_play_start <= (w_state_next == S_REQ);
      if (w_state_next != r_state) begin
        r_gap_cnt <= '0;
        r_to_cnt  <= '0;
      end else begin
        if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 32'd1;
        if (r_state == S_REQ) r_to_cnt  <= r_to_cnt + c_TO_W'(1);
      end
      // Head word is captured as the fetch begins so the ROM index is
      // already stable during FETCH and its data is valid during LOOKUP.
      if (w_fetch_go) begin
        r_cur <= r_mem[r_rd_ptr];
      end
      if (r_state == S_LOOKUP) begin
        r_start_addr <= tbl_start;
        r_end_addr   <= tbl_end;
      end
      if (w_ack_set) begin
        r_ack_error <= 1'b1;
      end
    end
  end

  assign full          = w_full;
  assign count         = r_count;
  assign busy          = (r_state != S_IDLE);
  assign tbl_index     = r_cur;
  assign start_address = r_start_addr;
  assign end_address   = r_end_addr;
  assign play_start    = r_play_start;
  assign ack_error     = r_ack_error;

endmodule

`default_nettype wire

// File: tb/tb_phrase_sequencer.sv
// ============================================================================
// Module   : tb_phrase_sequencer
// Purpose  : Directed self-checking bench for phrase_sequencer with a
//            registered address ROM and a simple audio-controller model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phrase_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic [4:0]  word_code;
  logic        clear;
  logic        full;
  logic [3:0]  count;
  logic        busy;
  logic [4:0]  tbl_index;
  logic [23:0] tbl_start;
  logic [23:0] tbl_end;
  logic [23:0] start_address;
  logic [23:0] end_address;
  logic        play_start;
  logic        play_finish;
  logic        ack_error;

  phrase_sequencer #(
    .DEPTH(8), .WORD_W(5), .GAP_CYCLES(4), .ACK_TIMEOUT(16), .SILENCE_CODE(5'h1F)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .word_code(word_code), .clear(clear),
    .full(full), .count(count), .busy(busy), .tbl_index(tbl_index),
    .tbl_start(tbl_start), .tbl_end(tbl_end), .start_address(start_address),
    .end_address(end_address), .play_start(play_start), .play_finish(play_finish),
    .ack_error(ack_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Address ROM: code c spans 0x000c00 .. 0x000cFF, one cycle latency.
  always @(posedge clk) begin
    tbl_start <= {11'd0, tbl_index, 8'h00};
    tbl_end   <= {11'd0, tbl_index, 8'hFF};
  end

  // Audio model: finish drops 2 cycles after a start edge, stays low 20 cycles.
  logic no_ack;
  logic ps_d;
  logic [1:0] am_ph;
  int   am_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      play_finish <= 1'b1;
      ps_d        <= 1'b0;
      am_ph       <= 2'd0;
      am_cnt      <= 0;
    end else begin
      ps_d <= play_start;
      case (am_ph)
        2'd0: if (play_start && !ps_d && !no_ack) am_ph <= 2'd1;
        2'd1: begin play_finish <= 1'b0; am_ph <= 2'd2; am_cnt <= 1; end
        default: begin
          if (am_cnt == 20) begin play_finish <= 1'b1; am_ph <= 2'd0; end
          else am_cnt <= am_cnt + 1;
        end
      endcase
    end
  end

  // Log every play_start rising edge with the addresses seen then and one cycle earlier.
  int          q_time[$];
  logic [23:0] q_sa[$];
  logic [23:0] q_ea[$];
  logic [23:0] q_pre_sa[$];
  logic [23:0] q_pre_ea[$];
  logic        ps_prev = 1'b0;
  logic        busy_prev = 1'b0;
  logic [23:0] prev_sa = '0;
  logic [23:0] prev_ea = '0;
  int          busy_fall = -1;
  always @(negedge clk) begin
    if (play_start && !ps_prev) begin
      q_time.push_back(cyc);
      q_sa.push_back(start_address);
      q_ea.push_back(end_address);
      q_pre_sa.push_back(prev_sa);
      q_pre_ea.push_back(prev_ea);
    end
    if (!busy && busy_prev) busy_fall = cyc;
    ps_prev   = play_start;
    busy_prev = busy;
    prev_sa   = start_address;
    prev_ea   = end_address;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [4:0] c, output int t);
    push = 1'b1;
    word_code = c;
    t = cyc;
    tick();
    push = 1'b0;
  endtask

  task automatic wait_rises(input int n, input int budget);
    int b = 0;
    while (q_time.size() < n && b < budget) begin tick(); b++; end
    if (q_time.size() < n) check("rise_timeout", q_time.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int b = 0;
    while ((busy || count != 0) && b < budget) begin tick(); b++; end
    if (busy || count != 0) check("idle_timeout", {31'd0, busy}, 0);
  endtask

  task automatic check_word(input string tag, input int i, input logic [4:0] c);
    check({tag, "_sa"},     32'(q_sa[i]),     {19'd0, c, 8'h00});
    check({tag, "_ea"},     32'(q_ea[i]),     {19'd0, c, 8'hFF});
    check({tag, "_pre_sa"}, 32'(q_pre_sa[i]), {19'd0, c, 8'h00});
  endtask

  initial begin
    int t0, t1, base, r, ta;
    reset = 1'b1; push = 1'b0; clear = 1'b0; word_code = '0; no_ack = 1'b0;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_count", {28'd0, count}, 0);
    check("rst_full", {31'd0, full}, 0);
    check("rst_play_start", {31'd0, play_start}, 0);
    check("rst_sa", 32'(start_address), 0);
    reset = 1'b0;
    tick();

    // Two words back to back: latency, spacing and busy drop.
    base = q_time.size();
    push_word(5'd3, t0);
    push_word(5'd7, t1);
    check("t1_count", {28'd0, count}, 2);
    wait_rises(base + 2, 200);
    wait_idle(200);
    if (q_time.size() >= base + 2) begin
      check("t1_first_latency", q_time[base], t0 + 5);
      check("t1_spacing", q_time[base+1] - q_time[base], 31);
      check_word("t1_w0", base, 5'd3);
      check_word("t1_w1", base + 1, 5'd7);
      check("t1_busy_fall", busy_fall, q_time[base+1] + 27);
    end
    check("t1_pulses", q_time.size() - base, 2);

    // Overflow while the first word plays; drain wraps the pointers.
    base = q_time.size();
    push_word(5'd1, t0);
    wait_rises(base + 1, 50);
    for (int i = 2; i <= 11; i++) push_word(5'(i), t1);
    check("t2_count", {28'd0, count}, 8);
    check("t2_full", {31'd0, full}, 1);
    wait_rises(base + 9, 600);
    wait_idle(600);
    check("t2_pulses", q_time.size() - base, 9);
    for (int i = 0; i < 9 && base + i < q_time.size(); i++)
      check("t2_order", 32'(q_sa[base+i]), {19'd0, 5'(i + 1), 8'h00});

    // Silence word between two words adds one extra gap plus FETCH/IDLE.
    base = q_time.size();
    push_word(5'd4, t0);
    push_word(5'h1F, t1);
    push_word(5'd5, t1);
    wait_rises(base + 2, 200);
    wait_idle(200);
    check("t3_pulses", q_time.size() - base, 2);
    if (q_time.size() >= base + 2) begin
      check("t3_spacing", q_time[base+1] - q_time[base], 37);
      check_word("t3_w1", base + 1, 5'd5);
    end

    // Controller never acknowledges: timeout, error flag, move on.
    base = q_time.size();
    no_ack = 1'b1;
    push_word(5'd6, t0);
    push_word(5'd8, t1);
    wait_rises(base + 1, 50);
    r = 0;
    while (!ack_error && r < 40) begin tick(); r++; end
    ta = cyc;
    check("t4_ack_error", {31'd0, ack_error}, 1);
    check("t4_play_start_low", {31'd0, play_start}, 0);
    if (q_time.size() > base) check("t4_ack_time", ta, q_time[base] + 16);
    no_ack = 1'b0;
    wait_rises(base + 2, 100);
    wait_idle(200);
    if (q_time.size() >= base + 2) begin
      check("t4_next_time", q_time[base+1], q_time[base] + 24);
      check_word("t4_next", base + 1, 5'd8);
    end

    // Clear during PLAY alongside a push: in-flight word finishes, rest flushed.
    base = q_time.size();
    push_word(5'd9, t0);
    wait_rises(base + 1, 50);
    for (int i = 10; i <= 13; i++) push_word(5'(i), t1);
    check("t5_count_before", {28'd0, count}, 4);
    clear = 1'b1;
    push_word(5'd14, t1);
    clear = 1'b0;
    check("t5_count_after", {28'd0, count}, 0);
    check("t5_busy_inflight", {31'd0, busy}, 1);
    wait_idle(200);
    repeat (10) tick();
    check("t5_pulses", q_time.size() - base, 1);
    check("t5_busy_end", {31'd0, busy}, 0);

    // Reset mid-PLAY with words queued, then normal operation resumes.
    base = q_time.size();
    push_word(5'd2, t0);
    wait_rises(base + 1, 50);
    push_word(5'd3, t1);
    push_word(5'd4, t1);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_count", {28'd0, count}, 0);
    check("t6_play_start", {31'd0, play_start}, 0);
    check("t6_ack_error", {31'd0, ack_error}, 0);
    check("t6_tbl_index", {27'd0, tbl_index}, 0);
    check("t6_sa", 32'(start_address), 0);
    check("t6_ea", 32'(end_address), 0);
    tick();
    reset = 1'b0;
    tick();
    push_word(5'd5, t0);
    wait_rises(base + 2, 50);
    wait_idle(200);
    check("t6_pulses", q_time.size() - base, 2);
    if (q_time.size() >= base + 2) begin
      check("t6_latency", q_time[base+1], t0 + 5);
      check_word("t6_after", base + 1, 5'd5);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
